// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT memory scheduler: widths, state encoding and
// the butterfly half-span / group helpers.
package ntt_pkg;

  localparam int NTT_ADDR_W = 12;
  localparam int NTT_LOG_N  = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_t;

  // Distance between the two operands of a butterfly in stage s.
  function automatic logic [31:0] half_of(input int log_n, input int s);
    return 32'd1 << (log_n - 1 - s);
  endfunction

  // Butterfly group that index k belongs to in stage s.
  function automatic logic [31:0] group_of(input int log_n, input int s, input logic [31:0] k);
    return k >> (log_n - 1 - s);
  endfunction

endpackage

// File: rtl/ntt_wr_delay.sv
// Fixed-depth shift register that turns a read issue into the matching
// write-back issue; cleared asynchronously so pending writes die on reset.
module ntt_wr_delay #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_mem_scheduler.sv
// In-place radix-2 NTT address sequencer: issues butterfly read pairs and
// twiddle indices, replays them as write-backs BF_LAT cycles later.
//
//  state | meaning
//  IDLE  | waiting for start
//  READ  | one butterfly read per cycle, k = 0 .. N/2-1
//  DRAIN | BF_LAT idle cycles so the stage's writes land before the next reads
//  DONE  | one-cycle done pulse
module ntt_mem_scheduler
  import ntt_pkg::*;
#(
  parameter int LOG_N  = NTT_LOG_N,
  parameter int BF_LAT = 6,
  parameter int ADDR_W = NTT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] tw_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b
);

  localparam int DW = $clog2(BF_LAT);
  localparam int WD = 1 + 2 * ADDR_W;
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'((1 << (LOG_N - 1)) - 1);
  localparam logic [3:0]        S_LAST = 4'(LOG_N - 1);
  localparam logic [DW-1:0]     D_LOAD = DW'(BF_LAT - 1);

  ntt_state_t        state, state_nx;
  logic [3:0]        s, s_nx;
  logic [ADDR_W-1:0] k, k_nx;
  logic [DW-1:0]     dcnt, dcnt_nx;
  logic [ADDR_W-1:0] half, grp, a_addr;
  logic [WD-1:0]     wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      s     <= '0;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      s     <= s_nx;
      k     <= k_nx;
      dcnt  <= dcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s;
    k_nx     = k;
    dcnt_nx  = dcnt;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_READ;
          s_nx     = '0;
          k_nx     = '0;
        end
      end
      ST_READ: begin
        if (k == K_LAST) begin
          state_nx = ST_DRAIN;
          dcnt_nx  = D_LOAD;
        end else begin
          k_nx = k + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dcnt == '0) begin
          if (s == S_LAST) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_READ;
            s_nx     = s + 1'b1;
            k_nx     = '0;
          end
        end else begin
          dcnt_nx = dcnt - 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        s_nx     = '0;
        k_nx     = '0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign half   = ADDR_W'(half_of(LOG_N, int'(s)));
  assign grp    = ADDR_W'(group_of(LOG_N, int'(s), 32'(k)));
  assign a_addr = (grp << (LOG_N - int'(s))) | (k & (half - 1'b1));

  assign rd_en     = (state == ST_READ);
  assign busy      = (state == ST_READ) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign stage     = busy ? s : 4'd0;
  assign rd_addr_a = rd_en ? a_addr : '0;
  assign rd_addr_b = rd_en ? (a_addr | half) : '0;
  assign tw_idx    = rd_en ? ((ADDR_W'(1) << s) + grp) : '0;

  ntt_wr_delay #(
    .DEPTH (BF_LAT),
    .WIDTH (WD)
  ) u_wr_delay (
    .clk (clk),
    .rst (rst),
    .d   ({rd_en, rd_addr_a, rd_addr_b}),
    .q   (wr_q)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = wr_q;

  // Operands differ in exactly one bit, so each pair spans both RAM banks.
  always_ff @(posedge clk) begin
    if (!rst && rd_en) begin
      assert (((rd_addr_a ^ rd_addr_b) == half) && $onehot(half))
        else $error("bank invariant violated: a=%0d b=%0d", rd_addr_a, rd_addr_b);
    end
  end

endmodule

// File: doc/ntt_mem_scheduler.md
Name: ntt_mem_scheduler

Overview:
- Sequences a full in-place radix-2 Cooley-Tukey NTT over the four-port coefficient memory (double_dual_port_ram).
- Read butterfly pairs go to ports a_1/b_1. Write-back pairs go to ports a_2/b_2, BF_LAT cycles later.
- Also issues the twiddle index per butterfly and drains the pipeline between stages so there are no read-after-write hazards.
- Sits between the top-level NTT control (start/done) and the memory plus butterfly datapath.

Parameters:
- LOG_N, 11: log2 of transform length N; legal range 2..12.
- BF_LAT, 6: cycles from read issue to write-back issue of the same butterfly (memory read latency 2 plus butterfly pipeline); must be >= 3.
- ADDR_W, 12: memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin transform; sampled only in IDLE
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse, transform complete
- stage  out  4  current stage index s
- rd_en  out  1  drives en_a_1 and en_b_1; we_a_1 = we_b_1 = 0
- rd_addr_a  out  ADDR_W  drives addr_a_1
- rd_addr_b  out  ADDR_W  drives addr_b_1
- tw_idx  out  ADDR_W  twiddle ROM index, valid with rd_en
- wr_en  out  1  drives en/we of a_2 and b_2
- wr_addr_a  out  ADDR_W  drives addr_a_2
- wr_addr_b  out  ADDR_W  drives addr_b_2

Behaviour:
- Reset: state IDLE; s = 0, k = 0; delay line cleared. All outputs 0 (busy, done, rd_en, wr_en, addresses, tw_idx, stage).
- Reset mid-transform aborts immediately. Pending writes are discarded: wr_en is 0 from reset assertion onward.
- FSM: IDLE -> READ -> DRAIN -> (READ | DONE) -> IDLE.
- IDLE:
  - start = 1 -> READ next cycle, with s = 0, k = 0, busy = 1.
  - start is ignored in every other state.
- READ:
  - rd_en = 1 every cycle for k = 0 .. N/2-1; k increments each cycle.
  - half = 2^(LOG_N-1-s); g = k >> (LOG_N-1-s); j = k & (half-1).
  - rd_addr_a = 2*g*half + j; rd_addr_b = rd_addr_a + half; tw_idx = 2^s + g.
  - Upper address bits above LOG_N are 0.
  - After k = N/2-1, go to DRAIN.
- DRAIN:
  - Lasts exactly BF_LAT cycles with rd_en = 0, so the last write of the stage issues in the final DRAIN cycle.
  - At the end: if s = LOG_N-1 go to DONE; else s++, k = 0, go to READ.
  - The next stage's first read is therefore one cycle after the last write: no same-address collision and no stale data.
- DONE: done = 1 for one cycle, busy drops in the same cycle, then IDLE.
- Write path:
  - Delay line of depth BF_LAT carries {rd_en, rd_addr_a, rd_addr_b}.
  - wr_en / wr_addr_a / wr_addr_b equal the rd_* values from BF_LAT cycles earlier.
- Bank invariant: rd_addr_a XOR rd_addr_b = half (single-bit difference), so the address parities differ. Every pair therefore lands in opposite RAM banks; this is checked by an assertion whenever rd_en = 1.
- Total latency: start sampled at cycle 0, done at cycle 1 + LOG_N*(N/2 + BF_LAT). Defaults give 11331.
- stage holds s during READ and DRAIN.

Decomposition:
- Shared package ntt_pkg: ADDR_W, LOG_N default, state encoding (IDLE, READ, DRAIN, DONE), half/group helper function.
- One sub-module, ntt_wr_delay: parameterised shift register (depth BF_LAT, width 1 + 2*ADDR_W) with asynchronous clear.

Test Plan:
- LOG_N = 3, BF_LAT = 3, start pulse:
  - stage 0 reads (0,4) (1,5) (2,6) (3,7), tw 1,1,1,1;
  - stage 1 reads (0,2) (1,3) (4,6) (5,7), tw 2,2,3,3;
  - stage 2 reads (0,1) (2,3) (4,5) (6,7), tw 4,5,6,7;
  - done at cycle 1 + 3*(4+3) = 22.
- Same configuration, write check: each wr_addr pair equals the read pair from exactly 3 cycles earlier. Last write of each stage occurs 1 cycle before the next stage's first read.
- Defaults, full run: done exactly once at cycle 11331. Parity assertion (rd_addr_a ^ rd_addr_b = one-hot half) holds on all 11264 reads.
- start held high during busy and re-pulsed mid-stage -> no restart; busy and done timing unchanged.
- rst asserted during stage 1 READ -> all outputs 0 immediately and no further wr_en pulses. A fresh start afterwards reproduces the first scenario exactly.
- LOG_N = 12, BF_LAT = 3: stage 0 first pair is (0,2048), last stage's last pair is (4094,4095). Upper address bits are correct; no overflow.
